// File: rtl/avs_pkg.sv
// avs_pkg: shared types and constants for the Avalon-MM slave RAM.
// Optional feature macro used by the including files: AVS_BYTEENABLE_EN.
package avs_pkg;

  localparam int AVS_DW    = 32;
  localparam int AVS_BE_W  = AVS_DW / 8;
  localparam int AVS_CNT_W = 4;

  localparam logic [AVS_DW-1:0] AVS_RDATA_IDLE = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } avs_state_e;

  // One write-port request into the storage array.
  typedef struct packed {
    logic [AVS_BE_W-1:0] lanes;
    logic [AVS_DW-1:0]   data;
  } avs_wr_t;

  // Byte lanes actually written: nothing unless the transfer commits.
  function automatic logic [AVS_BE_W-1:0] avs_wr_lanes(input logic commit,
                                                      input logic [AVS_BE_W-1:0] be);
    return commit ? be : '0;
  endfunction

endpackage

// File: rtl/avs_ram_array.sv
// avs_ram_array: word storage split into byte lanes; synchronous write with
// per-lane enables, asynchronous read. No reset: contents survive RST_N.
module avs_ram_array import avs_pkg::*; #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  avs_wr_t               wr_req,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [AVS_DW-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar l = 0; l < AVS_BE_W; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    // Byte-lane write at the clock edge ending the completion cycle.
    always_ff @(posedge clk) begin
      if (wr_req.lanes[l]) mem_q[waddr] <= wr_req.data[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem_q[raddr];
  end

endmodule

// File: rtl/avalon_mm_slave_ram.sv
// avalon_mm_slave_ram: Avalon-MM slave in front of a 2^DEPTH_LOG2 x 32 RAM
// with a fixed number of WAITREQUEST cycles per transfer and a sticky
// protocol-error flag. Define AVS_BYTEENABLE_EN to add the BYTEENABLE port.
module avalon_mm_slave_ram import avs_pkg::*; #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CHIPSELECT,
  input  logic [31:0]       ADDRESS,
  input  logic              BEGINTRANSFER,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [31:0]       WRITEDATA,
`ifdef AVS_BYTEENABLE_EN
  input  logic [3:0]        BYTEENABLE,
`endif
  output logic [31:0]       READDATA,
  output logic              WAITREQUEST,
  output logic              PROTO_ERR
);

  // Counter holds the number of stall cycles still owed after the current one.
  localparam logic [AVS_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? AVS_CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  avs_state_e state_q, state_d;
  logic [AVS_CNT_W-1:0] cnt_q, cnt_d;
  logic proto_err_q, proto_err_d;

  logic req, waitreq, complete, complete_g, rd_hit, be_err;
  logic [AVS_BE_W-1:0] wr_be;
  logic [DEPTH_LOG2-1:0] word_addr;
  logic [AVS_DW-1:0] rdata;
  avs_wr_t wr_req;
  logic unused_addr;

  assign req         = CHIPSELECT & (READ | WRITE);
  assign word_addr   = ADDRESS[DEPTH_LOG2+1:2];
  // Upper and byte-offset address bits are don't-care: the array aliases.
  assign unused_addr = ^ADDRESS;

`ifdef AVS_BYTEENABLE_EN
  assign wr_be  = BYTEENABLE;
  assign be_err = req & WRITE & (BYTEENABLE == '0);
`else
  assign wr_be  = '1;
  assign be_err = 1'b0;
`endif

  // Transfer FSM: stall WAIT_STATES cycles (first one spent in IDLE), then
  // one completion cycle in DONE; zero-wait completes straight from IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waitreq  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (ZERO_WAIT) begin
            complete = 1'b1;
          end else begin
            waitreq = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = (CNT_LOAD == '0) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        waitreq = 1'b1;
        if (!req) begin
          // Master abandoned the transfer: nothing commits.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == AVS_CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        complete = req;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky protocol error accumulation.
  always_comb begin
    proto_err_d = proto_err_q
                | ((state_q == WAIT) & ~req)
                | (req & READ & WRITE)
                | (BEGINTRANSFER & (state_q != IDLE))
                | be_err;
  end

  // State registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Reset gates the completion so neither data nor a write leaks out.
  assign complete_g   = complete & RST_N;
  assign rd_hit       = complete_g & READ & ~WRITE;
  assign wr_req.lanes = avs_wr_lanes(complete_g & WRITE, wr_be);
  assign wr_req.data  = WRITEDATA;

  avs_ram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk    (CLK),
    .wr_req (wr_req),
    .waddr  (word_addr),
    .raddr  (word_addr),
    .rdata  (rdata)
  );

  assign READDATA    = rd_hit ? rdata : AVS_RDATA_IDLE;
  assign WAITREQUEST = ~RST_N | waitreq;
  assign PROTO_ERR   = proto_err_q;

endmodule
